// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: multicycle CPU control FSM with a memory wait-state watchdog
module multi_cycle_controller #(
  parameter int MEM_WAIT_LIMIT = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       noOp,
  input  logic       moveTo,
  input  logic       memReady,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       iOrD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluOp,
  output logic       instrDone,
  output logic       memErr
);
  typedef enum logic [3:0] {
    S_IF, S_ID, S_LD_MEM, S_LD_WB, S_ST_MEM, S_JMP, S_BZ, S_C_EX, S_C_WB, S_I_EX, S_I_WB
  } state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic mem_err_q, mem_err_d;
  logic mem_st, timeout;
  logic pc_write, mem_read, mem_write, ir_write, reg_write;
  assign mem_st  = state_q inside {S_IF, S_LD_MEM, S_ST_MEM};
  assign timeout = mem_st && !memReady && wait_cnt_q == CNT_W'(MEM_WAIT_LIMIT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IF;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:     state_d = memReady ? S_ID : S_IF;
      S_ID:     state_d = opcode == 3'b000 ? S_LD_MEM :
                          opcode == 3'b001 ? S_ST_MEM :
                          opcode == 3'b010 ? S_JMP :
                          opcode == 3'b011 ? S_BZ :
                          opcode == 3'b100 ? S_C_EX : S_I_EX;
      S_LD_MEM: state_d = memReady ? S_LD_WB : timeout ? S_IF : S_LD_MEM;
      S_ST_MEM: state_d = (memReady || timeout) ? S_IF : S_ST_MEM;
      S_C_EX:   state_d = noOp ? S_IF : S_C_WB;
      S_I_EX:   state_d = S_I_WB;
      default:  state_d = S_IF;
    endcase
  end
  // A fetch timeout stays in IF but must still restart its wait count
  always_comb begin
    wait_cnt_d = (state_d != state_q || timeout) ? '0 :
                 (mem_st && !memReady) ? wait_cnt_q + 1'b1 : wait_cnt_q;
    mem_err_d  = mem_err_q | timeout;
  end
  always_comb begin
    pc_write  = 1'b0;
    pcSrc     = 2'b00;
    iOrD      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 3'b000;
    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        aluSrcB  = 2'b01;
        ir_write = memReady;
        pc_write = memReady;
      end
      S_LD_MEM: begin
        mem_read = 1'b1;
        iOrD     = 1'b1;
      end
      S_LD_WB: begin
        reg_write = 1'b1;
        memToReg  = 1'b1;
      end
      S_ST_MEM: begin
        mem_write = 1'b1;
        iOrD      = 1'b1;
      end
      S_JMP: begin
        pcSrc    = 2'b01;
        pc_write = 1'b1;
      end
      S_BZ: begin
        pcSrc    = 2'b01;
        pc_write = zero;
      end
      S_C_EX: begin
        aluSrcA = 1'b1;
        aluOp   = 3'b111;
      end
      S_C_WB: begin
        reg_write = 1'b1;
        regDst    = moveTo;
      end
      S_I_EX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        aluOp   = opcode == 3'b110 ? 3'b001 : opcode == 3'b111 ? 3'b010 : 3'b000;
      end
      S_I_WB:  reg_write = 1'b1;
      default: ;
    endcase
  end
  assign pcWrite   = pc_write & ~rst;
  assign memRead   = mem_read & ~rst;
  assign memWrite  = mem_write & ~rst;
  assign irWrite   = ir_write & ~rst;
  assign regWrite  = reg_write & ~rst;
  assign instrDone = state_q != S_IF && state_d == S_IF && !rst;
  assign memErr    = mem_err_q;
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: random instruction stream checked against a per-instruction procedural model
module tb_multi_cycle_controller;
  localparam int LIM = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] opcode = '0;
  logic zero = 1'b0, noOp = 1'b0, moveTo = 1'b0, memReady = 1'b0;
  logic pcWrite, iOrD, memRead, memWrite, irWrite, regWrite, regDst, memToReg, aluSrcA, instrDone, memErr;
  logic [1:0] pcSrc, aluSrcB;
  logic [2:0] aluOp;
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done, mem_err;
  } outs_t;
  outs_t got;
  int n_chk = 0, n_fail = 0;
  bit err_m = 1'b0;
  multi_cycle_controller #(.MEM_WAIT_LIMIT(LIM), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .noOp(noOp), .moveTo(moveTo),
    .memReady(memReady), .pcWrite(pcWrite), .pcSrc(pcSrc), .iOrD(iOrD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite), .regDst(regDst),
    .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .instrDone(instrDone), .memErr(memErr)
  );
  assign got = {pcWrite, pcSrc, iOrD, memRead, memWrite, irWrite, regWrite, regDst, memToReg,
                aluSrcA, aluSrcB, aluOp, instrDone, memErr};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [17:0] g, input logic [17:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, g, e);
    end
  endtask
  task automatic rnd_in();
    zero     = 1'($urandom);
    noOp     = 1'($urandom);
    moveTo   = 1'($urandom);
    memReady = 1'($urandom);
  endtask
  task automatic cyc(input string tag, input outs_t e);
    e.mem_err = err_m;
    #1 check(tag, got, e);
    @(negedge clk);
  endtask
  task automatic rst_cyc(input string tag);
    rnd_in();
    rst = 1'b1;
    #1 check(tag, {12'b0, pcWrite, irWrite, memRead, memWrite, regWrite, instrDone}, 18'b0);
    @(negedge clk);
    err_m = 1'b0;
  endtask
  function automatic int pick_d();
    int r = int'($urandom_range(0, 9));
    return r < 4 ? 0 : r < 7 ? int'($urandom_range(1, 3)) : r == 7 ? LIM - 1 : r == 8 ? LIM : 40;
  endfunction
  // kind: 0 fetch, 1 load, 2 store; d = cycles of memReady low before it rises
  task automatic mem_phase(input int kind, input int d, output bit ok);
    outs_t e;
    string tag = kind == 0 ? "IF" : kind == 1 ? "LD_MEM" : "ST_MEM";
    ok = 1'b0;
    for (int k = 0; k < LIM && !ok; k++) begin
      rnd_in();
      memReady = k >= d;
      e = '0;
      if (kind == 0) begin
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b01;
        e.ir_write  = memReady;
        e.pc_write  = memReady;
      end else begin
        e.i_or_d     = 1'b1;
        e.mem_read   = kind == 1;
        e.mem_write  = kind == 2;
        e.instr_done = (kind == 2 && memReady) || (!memReady && k == LIM - 1);
      end
      cyc(tag, e);
      ok = memReady;
    end
    if (!ok) err_m = 1'b1;
  endtask
  task automatic fetch(input int df);
    bit ok = 1'b0;
    for (int t = 0; !ok; t++) mem_phase(0, t == 0 && df >= 0 ? df : t < 3 ? pick_d() : 0, ok);
  endtask
  task automatic run_instr(input logic [2:0] op, input int df, input int dm);
    outs_t e;
    bit ok;
    int d;
    opcode = op;
    fetch(df);
    rnd_in();
    e = '0;
    cyc("ID", e);
    d = dm < 0 ? pick_d() : dm;
    case (op)
      3'd0: begin
        mem_phase(1, d, ok);
        if (ok) begin
          rnd_in(); e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
          cyc("LD_WB", e);
        end
      end
      3'd1: mem_phase(2, d, ok);
      3'd2: begin
        rnd_in(); e = '0; e.pc_src = 2'b01; e.pc_write = 1'b1; e.instr_done = 1'b1;
        cyc("JMP", e);
      end
      3'd3: begin
        rnd_in(); e = '0; e.pc_src = 2'b01; e.pc_write = zero; e.instr_done = 1'b1;
        cyc("BZ", e);
      end
      3'd4: begin
        rnd_in(); e = '0; e.alu_src_a = 1'b1; e.alu_op = 3'b111; e.instr_done = noOp;
        cyc("C_EX", e);
        if (!noOp) begin
          rnd_in(); e = '0; e.reg_write = 1'b1; e.reg_dst = moveTo; e.instr_done = 1'b1;
          cyc("C_WB", e);
        end
      end
      default: begin
        rnd_in(); e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = op - 3'd5;
        cyc("I_EX", e);
        rnd_in(); e = '0; e.reg_write = 1'b1; e.instr_done = 1'b1;
        cyc("I_WB", e);
      end
    endcase
  endtask
  initial begin
    outs_t e;
    rst_cyc("reset0");
    rst_cyc("reset1");
    rst = 1'b0;
    run_instr(3'd0, 0, 0);
    run_instr(3'd3, 0, 0);
    run_instr(3'd3, 0, 0);
    run_instr(3'd4, 0, 0);
    run_instr(3'd1, 0, 3);
    run_instr(3'd1, 0, LIM - 1);
    run_instr(3'd1, 0, 99);
    run_instr(3'd7, 0, 0);
    run_instr(3'd0, 0, 40);
    run_instr(3'd2, 40, 0);
    for (int i = 0; i < 300; i++) run_instr(3'($urandom), -1, -1);
    opcode = 3'd1;
    fetch(0);
    rnd_in(); e = '0;
    cyc("ID", e);
    rnd_in(); memReady = 1'b0; e = '0; e.i_or_d = 1'b1; e.mem_write = 1'b1;
    cyc("ST_MEM", e);
    rst_cyc("rst_in_st");
    rst = 1'b0;
    run_instr(3'd5, 0, 0);
    for (int i = 0; i < 50; i++) run_instr(3'($urandom), -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
